// File: rtl/io_clock_pkg.sv
// rtl/io_clock_pkg.sv - shared types and constants for IO clock recovery
// Purpose: state encoding of the recovery FSM and synchroniser depth floor.
// Ports: none (package).
package io_clock_pkg;

  typedef enum logic [1:0] {
    DISABLED,
    ARMED,
    LOCKING,
    TRACKING
  } io_clk_rec_state_t;

  localparam int IO_CLK_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/io_clock_recovery_if.sv
// rtl/io_clock_recovery_if.sv - recovered-clock status/strobe bundle
// Purpose: carries the recovered clock level, edge/center strobes and lock
//   status from the recovery block to the serial shift logic.
// Modports: master = recovery block (drives), slave = consumer (reads).
interface io_clock_recovery_if #(
  parameter int COUNT_W = 16
);

  logic               clock_state;
  logic               first_edge;
  logic               second_edge;
  logic               first_center;
  logic               second_center;
  logic [COUNT_W-1:0] half_period;
  logic               locked;
  logic               timeout;

  modport master (
    output clock_state, first_edge, second_edge, first_center,
           second_center, half_period, locked, timeout
  );

  modport slave (
    input clock_state, first_edge, second_edge, first_center,
          second_center, half_period, locked, timeout
  );

endinterface

// File: rtl/io_sync_bit.sv
// rtl/io_sync_bit.sv - multi-flop single-bit synchroniser
// Purpose: brings an asynchronous level into the clk domain.
// Ports: clk, rst_n (async active-low), d (async input), q (synchronised).
module io_sync_bit
  import io_clock_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  // Depth below the floor is silently raised to keep metastability margin.
  localparam int N = (STAGES < IO_CLK_MIN_SYNC_STAGES) ? IO_CLK_MIN_SYNC_STAGES : STAGES;

  logic [N-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d};
    end
  end

  assign q = sync_q[N-1];

endmodule

// File: rtl/io_clock_recovery.sv
// rtl/io_clock_recovery.sv - serial clock recovery with edge/center strobes
// Purpose: synchronises sclk_in, classifies edges against the idle polarity,
//   measures the edge-to-edge interval and emits center strobes; detects
//   loss of clock through an idle timeout.
// Ports: clk, async_rst_n, clk_en, enable, default_sclk_polarity,
//   idle_timeout, sclk_in; outputs via rec (io_clock_recovery_if.master):
//   clock_state, first_edge, second_edge, first_center, second_center,
//   half_period, locked, timeout.
// Option: IO_CLOCK_RECOVERY_GLITCH_FILTER_EN - accept an edge only after the
//   new level is stable for two consecutive clk_en samples.
module io_clock_recovery
  import io_clock_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_W     = 16
) (
  input  logic               clk,
  input  logic               async_rst_n,
  input  logic               clk_en,
  input  logic               enable,
  input  logic               default_sclk_polarity,
  input  logic [COUNT_W-1:0] idle_timeout,
  input  logic               sclk_in,
  io_clock_recovery_if.master rec
);

  io_clk_rec_state_t  state_q, state_n;
  logic               clock_state;
  logic               prev_level_q, prev_level_n;
  logic [COUNT_W-1:0] counter_q, counter_n;
  logic [COUNT_W-1:0] half_q, half_n;
  logic               last_first_q, last_first_n;
  logic               fe_q, fe_n, se_q, se_n;
  logic               fc_q, fc_n, sc_q, sc_n;
  logic               to_q, to_n;
  logic               level_stable;
  logic               edge_det;
  logic               is_first;
  logic [COUNT_W-1:0] cnt_inc;

  io_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (async_rst_n),
    .d     (sclk_in),
    .q     (clock_state)
  );

`ifdef IO_CLOCK_RECOVERY_GLITCH_FILTER_EN
  logic last_sample_q;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      last_sample_q <= 1'b0;
    end else if (clk_en) begin
      last_sample_q <= clock_state;
    end
  end

  assign level_stable = (clock_state == last_sample_q);
`else
  assign level_stable = 1'b1;
`endif

  // prev_level holds the last accepted level, so an unaccepted pulse that
  // returns to it produces nothing.
  assign edge_det = (clock_state != prev_level_q) && level_stable;
  assign is_first = (clock_state != default_sclk_polarity);
  assign cnt_inc  = (counter_q == '1) ? counter_q : counter_q + 1'b1;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q      <= DISABLED;
      prev_level_q <= 1'b0;
      counter_q    <= '0;
      half_q       <= '0;
      last_first_q <= 1'b0;
      fe_q         <= 1'b0;
      se_q         <= 1'b0;
      fc_q         <= 1'b0;
      sc_q         <= 1'b0;
      to_q         <= 1'b0;
    end else if (clk_en) begin
      state_q      <= state_n;
      prev_level_q <= prev_level_n;
      counter_q    <= counter_n;
      half_q       <= half_n;
      last_first_q <= last_first_n;
      fe_q         <= fe_n;
      se_q         <= se_n;
      fc_q         <= fc_n;
      sc_q         <= sc_n;
      to_q         <= to_n;
    end
  end

  // Center/timeout compare against cnt_inc: the counter value in the cycle
  // the registered strobe is visible, keeping them aligned to the edge strobe.
  always_comb begin
    state_n      = state_q;
    prev_level_n = prev_level_q;
    counter_n    = cnt_inc;
    half_n       = half_q;
    last_first_n = last_first_q;
    fe_n         = 1'b0;
    se_n         = 1'b0;
    fc_n         = 1'b0;
    sc_n         = 1'b0;
    to_n         = 1'b0;

    if (!enable) begin
      state_n      = DISABLED;
      prev_level_n = clock_state;
      counter_n    = '0;
    end else begin
      case (state_q)
        DISABLED: begin
          state_n      = ARMED;
          prev_level_n = clock_state;
          counter_n    = '0;
        end
        default: begin
          if (edge_det) begin
            prev_level_n = clock_state;
            counter_n    = '0;
            last_first_n = is_first;
            fe_n         = is_first;
            se_n         = !is_first;
            if (state_q == ARMED) begin
              state_n = LOCKING;
            end else begin
              state_n = TRACKING;
              half_n  = cnt_inc;
            end
          end else begin
            if ((state_q == TRACKING) && (half_q >= COUNT_W'(2)) &&
                (cnt_inc == (half_q >> 1))) begin
              fc_n = last_first_q;
              sc_n = !last_first_q;
            end
            if ((state_q != ARMED) && (idle_timeout != '0) &&
                (cnt_inc == idle_timeout)) begin
              to_n    = 1'b1;
              state_n = ARMED;
            end
          end
        end
      endcase
    end
  end

  assign rec.clock_state   = clock_state;
  assign rec.first_edge    = fe_q;
  assign rec.second_edge   = se_q;
  assign rec.first_center  = fc_q;
  assign rec.second_center = sc_q;
  assign rec.half_period   = half_q;
  assign rec.locked        = (state_q == TRACKING);
  assign rec.timeout       = to_q;

endmodule

// File: tb/tb_io_clock_recovery.sv
// tb/tb_io_clock_recovery.sv - scoreboard bench for io_clock_recovery
module tb_io_clock_recovery;

  localparam int SYNC      = 2;
  localparam int CW        = 16;
  localparam int ENA_START = 4;
  localparam int MAXN      = 2048;
  localparam int K_FE = 0, K_SE = 1, K_FC = 2, K_SC = 3, K_TO = 4;
`ifdef IO_CLOCK_RECOVERY_GLITCH_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          async_rst_n = 1'b0;
  logic          clk_en = 1'b0;
  logic          enable = 1'b0;
  logic          default_sclk_polarity = 1'b0;
  logic [CW-1:0] idle_timeout = '0;
  logic          sclk_in = 1'b0;

  io_clock_recovery_if #(.COUNT_W(CW)) rec ();

  io_clock_recovery #(.SYNC_STAGES(SYNC), .COUNT_W(CW)) dut (
    .clk                   (clk),
    .async_rst_n           (async_rst_n),
    .clk_en                (clk_en),
    .enable                (enable),
    .default_sclk_polarity (default_sclk_polarity),
    .idle_timeout          (idle_timeout),
    .sclk_in               (sclk_in),
    .rec                   (rec)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int j;
    int hp;
    bit lk;
  } ev_t;

  ev_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cur_j = -1;
  bit   mon_on = 1'b0;
  bit   sclk_a[MAXN];
  bit   en_a[MAXN];
  int   n_len;
  logic [4:0] mon_s;

  function automatic string kname(int k);
    case (k)
      K_FE:    return "first_edge";
      K_SE:    return "second_edge";
      K_FC:    return "first_center";
      K_SC:    return "second_center";
      default: return "timeout";
    endcase
  endfunction

  task automatic chk(string name, int got, int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic seg(bit lvl, int len);
    for (int i = 0; i < len; i++) begin
      if (n_len < MAXN) begin
        sclk_a[n_len] = lvl;
        n_len++;
      end
    end
  endtask

  task automatic fill_en(int mode);
    for (int k = 0; k < MAXN; k++) begin
      case (mode)
        0:       en_a[k] = 1'b1;
        1:       en_a[k] = (k % 2 == 0);
        default: en_a[k] = ($urandom_range(0, 9) < 7);
      endcase
    end
  endtask

  task automatic push_ev(int k, int j, int hp, bit lk);
    ev_t e;
    e.kind = k;
    e.j    = j;
    e.hp   = hp;
    e.lk   = lk;
    exp_q.push_back(e);
  endtask

  // Reference: list the level seen at each enabled sample, extract accepted
  // edges, then walk the edge list deriving edge/center/timeout events.
  task automatic model_run();
    int lv[$];
    bit act[$];
    int ej[$];
    bit et[$];
    int j_end, arm, acc, phase, prev, hp, nxt, tpt, c, t;
    bit lastf, to_hit;
    t = int'(idle_timeout);
    for (int k = 0; k < n_len; k++) begin
      if (en_a[k]) begin
        lv.push_back((k >= SYNC) ? int'(sclk_a[k-SYNC]) : 0);
        act.push_back(k >= ENA_START);
      end
    end
    j_end = lv.size();
    arm = -1;
    for (int j = 0; j < j_end; j++) begin
      if (act[j]) begin
        arm = j;
        break;
      end
    end
    if (arm < 0) return;
    acc = lv[arm];
    for (int j = arm + 1; j < j_end; j++) begin
      if (lv[j] != acc && (!FILT || lv[j] == lv[j-1])) begin
        acc = lv[j];
        ej.push_back(j);
        et.push_back(lv[j] != int'(default_sclk_polarity));
      end
    end
    phase = 0;
    prev  = arm;
    hp    = 0;
    lastf = 1'b0;
    for (int i = 0; i <= ej.size(); i++) begin
      nxt    = (i < ej.size()) ? ej[i] : j_end;
      tpt    = prev + t;
      to_hit = (phase >= 1) && (t != 0) && (tpt < nxt);
      if (phase == 2 && hp >= 2) begin
        c = prev + hp / 2;
        if (c < nxt && (t == 0 || c <= tpt))
          push_ev(lastf ? K_FC : K_SC, c, hp, !(to_hit && c == tpt));
      end
      if (to_hit) begin
        push_ev(K_TO, tpt, hp, 1'b0);
        phase = 0;
      end
      if (i < ej.size()) begin
        if (phase == 0) begin
          phase = 1;
        end else begin
          hp    = nxt - prev;
          phase = 2;
        end
        lastf = et[i];
        push_ev(et[i] ? K_FE : K_SE, nxt, hp, phase == 2);
        prev = nxt;
      end
    end
  endtask

  task automatic check_ev(int k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got strobe at j=%0d, required none", kname(k), cur_j);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.j != cur_j || e.hp != int'(rec.half_period) || e.lk != rec.locked) begin
        errors++;
        $display("FAIL strobe_%s: got %s j=%0d hp=%0d locked=%0d, required %s j=%0d hp=%0d locked=%0d",
                 kname(e.kind), kname(k), cur_j, rec.half_period, rec.locked,
                 kname(e.kind), e.j, e.hp, e.lk);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on && async_rst_n && clk_en) begin
      mon_s = {rec.timeout, rec.second_center, rec.first_center, rec.second_edge, rec.first_edge};
      for (int kk = 0; kk < 5; kk++) begin
        if (mon_s[kk]) check_ev(kk);
      end
    end
  end

  task automatic drive_run(string name);
    int jj;
    jj = 0;
    mon_on = 1'b1;
    async_rst_n = 1'b0;
    enable = 1'b0;
    clk_en = 1'b1;
    sclk_in = default_sclk_polarity;
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_rst_n = 1'b1;
    cur_j = -1;
    for (int k = 0; k < n_len; k++) begin
      sclk_in = sclk_a[k];
      clk_en  = en_a[k];
      enable  = (k >= ENA_START);
      @(posedge clk);
      if (en_a[k]) begin
        cur_j = jj;
        jj++;
      end
      #1;
    end
    enable = 1'b0;
    clk_en = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: got %0d unseen strobes, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic run_case(string name, bit pol, int t, int emode);
    default_sclk_polarity = pol;
    idle_timeout = CW'(t);
    fill_en(emode);
    model_run();
    drive_run(name);
  endtask

  task automatic build_toggle(bit pol, int n, int len);
    bit lvl;
    n_len = 0;
    seg(pol, 10);
    lvl = !pol;
    for (int i = 0; i < n; i++) begin
      seg(lvl, len);
      lvl = !lvl;
    end
    seg(pol, 40);
  endtask

  task automatic reset_test();
    mon_on = 1'b0;
    default_sclk_polarity = 1'b0;
    idle_timeout = '0;
    async_rst_n = 1'b0;
    clk_en = 1'b1;
    enable = 1'b0;
    sclk_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      sclk_in = (k >= 10) ? (((k - 10) / 8) % 2 == 0) : 1'b0;
      enable  = (k >= ENA_START);
      @(posedge clk);
      #1;
    end
    chk("pre_reset_locked", int'(rec.locked), 1);
    chk("pre_reset_half_period", int'(rec.half_period), 8);
    @(negedge clk);
    #2;
    async_rst_n = 1'b0;
    #1;
    chk("reset_flags", int'({rec.clock_state, rec.first_edge, rec.second_edge, rec.first_center,
                             rec.second_center, rec.locked, rec.timeout}), 0);
    chk("reset_half_period", int'(rec.half_period), 0);
    sclk_in = 1'b0;
    @(negedge clk);
    async_rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_strobes", int'({rec.first_edge, rec.second_edge, rec.first_center,
                                    rec.second_center, rec.timeout}), 0);
    chk("post_reset_locked", int'(rec.locked), 0);
  endtask

  initial begin
    bit lvl;
    int t;

    reset_test();

    build_toggle(1'b0, 10, 8);
    run_case("basic", 1'b0, 0, 0);

    build_toggle(1'b1, 10, 8);
    run_case("polarity", 1'b1, 0, 0);

    n_len = 0;
    seg(1'b0, 10);
    lvl = 1'b1;
    for (int i = 0; i < 6; i++) begin
      seg(lvl, 8);
      lvl = !lvl;
    end
    seg(1'b0, 60);
    for (int i = 0; i < 4; i++) begin
      seg(lvl, 8);
      lvl = !lvl;
    end
    seg(1'b0, 40);
    run_case("timeout", 1'b0, 20, 0);

    build_toggle(1'b0, 8, 16);
    run_case("half_rate", 1'b0, 0, 1);

    n_len = 0;
    seg(1'b0, 10);
    seg(1'b1, 1);
    seg(1'b0, 40);
    run_case("glitch", 1'b0, 0, 0);

    for (int r = 0; r < 12; r++) begin
      bit pol;
      pol = 1'(($urandom_range(0, 1)));
      t = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(6, 40));
      n_len = 0;
      seg(pol, 10);
      lvl = !pol;
      for (int s = 0; s < 14; s++) begin
        seg(lvl, ($urandom_range(0, 5) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(1, 18)));
        lvl = !lvl;
      end
      seg(sclk_a[n_len-1], 50);
      run_case("random", pol, t, int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/io_clock_recovery.md
Name: io_clock_recovery

Overview:
- Receive-side counterpart of the IO clock divider.
- Synchronises an externally driven serial clock (sclk_in) into the clk domain and classifies its transitions as first/second edges against the idle polarity.
- Measures the half-period between edges and emits estimated first/second center strobes for data sampling.
- Detects loss of clock via a programmable idle timeout; sits between the pad and a serial target/shift block.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on sclk_in (min 2)
COUNT_W, 16, width of the edge-interval counter and the measured half-period

Ports:
clk  in  1  system clock
async_rst_n  in  1  asynchronous active-low reset
clk_en  in  1  clock enable; all state except the synchroniser advances only when 1
enable  in  1  level; 1 = recovery active, 0 = DISABLED
default_sclk_polarity  in  1  idle level of sclk_in
idle_timeout  in  COUNT_W  clk_en cycles without an edge before timeout; 0 = timeout off
sclk_in  in  1  asynchronous serial clock from pad
clock_state  out  1  synchronised sclk level
first_edge  out  1  strobe: transition away from idle level
second_edge  out  1  strobe: transition back to idle level
first_center  out  1  strobe: estimated midpoint after a first edge
second_center  out  1  strobe: estimated midpoint after a second edge
half_period  out  COUNT_W  last measured edge-to-edge interval, in clk_en cycles
locked  out  1  1 while in TRACKING
timeout  out  1  strobe: idle timeout expired

Behaviour:
- Reset: all outputs 0, synchroniser flops 0, state DISABLED, counter 0, half_period 0.
- Synchroniser: SYNC_STAGES flops clocked every clk, independent of clk_en. clock_state is the last stage.
- Edge detection: a prev_level register is compared with clock_state.
  - While DISABLED, prev_level loads clock_state, so enabling never produces a spurious edge.
  - Edge strobe is registered; latency is SYNC_STAGES+1 clk from the sclk_in change with clk_en=1.
  - Classification: clock_state != default_sclk_polarity gives first_edge; otherwise second_edge.
- Counter: cleared to 0 in the edge cycle, +1 per clk_en cycle, saturates at all-ones.
  - At each edge, half_period <= counter+1 (saturating), i.e. the interval in clk_en cycles since the previous edge.
- Centers: target = half_period>>1.
  - Fires once per interval when counter == target, state is TRACKING and half_period >= 2.
  - The edge type of the last edge selects first_center or second_center.
- FSM states: DISABLED, ARMED, LOCKING, TRACKING.
  - DISABLED -> ARMED when enable=1.
  - ARMED -> LOCKING on the first edge (half_period not updated).
  - LOCKING -> TRACKING on the next edge (half_period updated).
  - TRACKING stays in TRACKING on each edge.
  - Any state -> DISABLED when enable=0.
  - LOCKING or TRACKING -> ARMED with timeout=1 for one cycle when idle_timeout != 0 and counter == idle_timeout.
- Simultaneous events:
  - enable=0 together with an edge: DISABLED wins, no strobe.
  - Edge together with timeout: edge wins, no timeout.
  - Edge together with center: edge wins and the center is dropped.
- Strobe width: all strobes are high for exactly one clk_en-qualified cycle. Consumers qualify them with clk_en.
- Reset mid-operation: immediate return to reset values; no strobe in the cycle after deassertion.

Optional Feature:
- IO_CLOCK_RECOVERY_GLITCH_FILTER_EN defined:
  - An edge is accepted only after the new synchronised level has been stable for 2 consecutive clk_en samples.
  - Edge latency grows by 1 clk_en cycle.
  - Single-cycle pulses are rejected.
  - Counter and half_period reference the accepted edge.
- Undefined: every synchronised transition is an edge.

Decomposition:
- Shared package io_clock_pkg holds:
  - typedef enum logic [1:0] io_clk_rec_state_t {DISABLED, ARMED, LOCKING, TRACKING};
  - localparam IO_CLK_MIN_SYNC_STAGES = 2.
- One natural sub-module: io_sync_bit, a parameterised multi-flop synchroniser with async active-low reset.

Test Plan:
- Reset: assert async_rst_n low while TRACKING -> all outputs 0, locked=0, half_period=0. Deassert -> no strobe for 1 cycle.
- Basic tracking: SYNC_STAGES=2, default=0, clk_en=1, sclk_in toggles every 8 clk.
  - first_edge 3 clk after the first rise, locked=1 at the next edge, half_period=8.
  - first_center/second_center exactly 4 clk after each respective edge strobe.
- Polarity swap: default_sclk_polarity=1 with the same stimulus -> falling sclk_in gives first_edge and rising gives second_edge.
- Timeout: idle_timeout=20, sclk_in stops after lock -> timeout pulses 20 clk_en cycles after the last edge strobe and locked=0.
  - Next edge -> LOCKING with no centers; the following edge -> TRACKING.
- clk_en at 50% duty, sclk_in toggling every 16 clk -> half_period=8; centers 4 enabled cycles after each edge.
- Glitch: 1-clk high pulse on idle sclk_in.
  - Macro defined -> no strobes.
  - Macro undefined -> first_edge then second_edge; state LOCKING then TRACKING with half_period=1, no centers.
